// File: rtl/latent_stream_unpacker.sv
// latent_stream_unpacker
// Reassembles 32-bit latent codes (16 neurons x 2 bits, neuron n at bits
// [2n+1:2n]) from an LSB-first beat stream with start-of-frame marking.
// Completed codes sit in a registered valid/ready output slot; framing
// errors (stray beats while hunting, premature SOF) are counted, saturating.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | no frame open; waiting for a beat with s_sof=1
// COLLECT | frame open; beat_idx is the slot of the next expected beat

module latent_stream_unpacker #(
   parameter int CODE_W = 32,
   parameter int BEAT_W = 8,
   parameter int ERR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BEAT_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_sof,
   output logic              s_ready,
   output logic [CODE_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ERR_W-1:0]  err_count
);

   localparam int BEATS = CODE_W / BEAT_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [0:0] HUNT    = 1'b0;
   localparam logic [0:0] COLLECT = 1'b1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   logic [0:0]        state, state_n;
   logic [IDX_W-1:0]  beat_idx, beat_idx_n;
   logic [CODE_W-1:0] asm_q, asm_n;
   logic [CODE_W-1:0] code_done;
   logic              completes;
   logic              accept;
   logic              load;
   logic              err_evt;

   // A beat that would finish a frame must wait while the output slot is full
   // and not being drained; every other beat is always accepted.
   always_comb begin
      if (BEATS == 1)
         completes = s_sof;
      else
         completes = (state == COLLECT) && (beat_idx == IDX_LAST) && !s_sof;
      s_ready = rst || !(completes && m_valid && !m_ready);
   end

   assign accept = s_valid && s_ready;

   // Frame assembly and framing-error detection.
   always_comb begin
      state_n    = state;
      beat_idx_n = beat_idx;
      asm_n      = asm_q;
      load       = 1'b0;
      err_evt    = 1'b0;
      code_done  = asm_q;
      code_done[(BEATS-1)*BEAT_W +: BEAT_W] = s_data;
      if (accept) begin
         if (BEATS == 1) begin
            if (s_sof)
               load = 1'b1;
            else
               err_evt = 1'b1;
         end else begin
            case (state)
               HUNT: begin
                  if (s_sof) begin
                     asm_n[BEAT_W-1:0] = s_data;
                     beat_idx_n        = IDX_ONE;
                     state_n           = COLLECT;
                  end else begin
                     err_evt = 1'b1;
                  end
               end
               default: begin
                  if (s_sof) begin
                     // premature SOF: restart the frame on this beat
                     err_evt           = 1'b1;
                     asm_n[BEAT_W-1:0] = s_data;
                     beat_idx_n        = IDX_ONE;
                  end else if (beat_idx == IDX_LAST) begin
                     load       = 1'b1;
                     beat_idx_n = '0;
                     state_n    = HUNT;
                  end else begin
                     asm_n[beat_idx*BEAT_W +: BEAT_W] = s_data;
                     beat_idx_n = beat_idx + IDX_ONE;
                  end
               end
            endcase
         end
      end
   end

   // Framing state and assembly register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         beat_idx <= '0;
         asm_q    <= '0;
      end else begin
         state    <= state_n;
         beat_idx <= beat_idx_n;
         asm_q    <= asm_n;
      end
   end

   // Output slot: a load wins over a consume so back-to-back codes never bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= code_done;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Saturating framing-error counter.
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (err_evt && (err_count != ERR_MAX))
         err_count <= err_count + 1'b1;
   end

endmodule

// File: tb/tb_latent_stream_unpacker.sv
// Bench for latent_stream_unpacker: directed beat vectors, expected codes
// queued at stimulus time and checked by an independent output monitor.

module tb_latent_stream_unpacker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_sof = 1'b0;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [15:0] err_count;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_q[$];
   logic [31:0] held_data;
   bit          hold_prev = 0;

   latent_stream_unpacker dut (
      .clk       (clk),
      .rst       (rst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_sof     (s_sof),
      .s_ready   (s_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Output monitor: pops on each handshake, checks hold stability under stall.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_code", m_data, 32'hxxxxxxxx);
         end else begin
            chk("code", m_data, exp_q.pop_front());
         end
      end
      if (!rst && m_valid && !m_ready) begin
         if (hold_prev) chk("hold_stable", m_data, held_data);
         held_data = m_data;
         hold_prev = 1;
      end else begin
         hold_prev = 0;
      end
   end

   // Offer one beat until accepted; optionally check the number of stall cycles.
   task automatic send(input logic [7:0] d, input logic sof, input int exp_stall);
      int  stall = 0;
      bit  done = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (s_ready) done = 1;
         else stall++;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (!done) chk("beat_timeout", 32'(stall), 32'(exp_stall));
      else if (exp_stall >= 0) chk("stall_cycles", 32'(stall), 32'(exp_stall));
   endtask

   task automatic send_frame(input logic [31:0] code, input int last_stall);
      exp_q.push_back(code);
      send(code[7:0],   1'b1, 0);
      send(code[15:8],  1'b0, 0);
      send(code[23:16], 1'b0, 0);
      send(code[31:24], 1'b0, last_stall);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("s_ready_in_reset", 32'(s_ready), 32'd1);
      idle(2);
      rst = 1'b0;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'h0);
      chk("rst_err_count", 32'(err_count), 32'h0);
   endtask

   initial begin
      // reset state
      idle(1);
      do_reset();
      chk("idle_s_ready", 32'(s_ready), 32'd1);

      // clean frame, one-cycle latency
      m_ready = 1'b1;
      send_frame(32'hFF00E41B, 0);
      chk("clean_m_valid", 32'(m_valid), 32'd1);
      chk("clean_m_data", m_data, 32'hFF00E41B);
      chk("clean_err", 32'(err_count), 32'h0);
      idle(3);
      chk("clean_drained", 32'(m_valid), 32'd0);

      // back-to-back with backpressure
      m_ready = 1'b0;
      fork
         begin
            send_frame(32'h44332211, 0);
            send_frame(32'h88776655, 3);
         end
         begin
            bit seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
               @(negedge clk);
               if (s_valid && !s_ready) seen = 1;
            end
            if (!seen) chk("bp_stall_seen", 32'd0, 32'd1);
            idle(3);
            m_ready = 1'b1;
         end
      join
      chk("bp_m_data", m_data, 32'h88776655);
      idle(3);
      chk("bp_drained", 32'(exp_q.size()), 32'd0);

      // simultaneous consume and load
      m_ready = 1'b0;
      send_frame(32'hCAFE0102, 0);
      exp_q.push_back(32'h5A6B7C8D);
      send(8'h8D, 1'b1, 0);
      send(8'h7C, 1'b0, 0);
      send(8'h6B, 1'b0, 0);
      m_ready = 1'b1;
      send(8'h5A, 1'b0, 0);
      chk("sim_m_valid", 32'(m_valid), 32'd1);
      chk("sim_m_data", m_data, 32'h5A6B7C8D);
      idle(3);
      chk("sim_drained", 32'(exp_q.size()), 32'd0);

      // stray beat in HUNT
      do_reset();
      send(8'h55, 1'b0, 0);
      chk("stray_err", 32'(err_count), 32'd1);
      send_frame(32'h04030201, 0);
      chk("stray_m_data", m_data, 32'h04030201);
      idle(2);
      chk("stray_err_after", 32'(err_count), 32'd1);

      // premature SOF
      do_reset();
      send(8'h11, 1'b1, 0);
      send(8'h22, 1'b0, 0);
      chk("presof_no_output", 32'(m_valid), 32'd0);
      send_frame(32'hD4C3B2A1, 0);
      chk("presof_err", 32'(err_count), 32'd1);
      chk("presof_m_data", m_data, 32'hD4C3B2A1);
      idle(3);
      chk("presof_drained", 32'(exp_q.size()), 32'd0);

      // reset mid-frame
      send(8'h99, 1'b1, 0);
      send(8'h98, 1'b0, 0);
      do_reset();
      send_frame(32'h0D0C0B0A, 0);
      chk("midrst_m_data", m_data, 32'h0D0C0B0A);
      chk("midrst_err", 32'(err_count), 32'd0);
      idle(3);

      // saturation
      do_reset();
      s_valid = 1'b1;
      s_sof   = 1'b0;
      s_data  = 8'h00;
      idle(65534);
      s_valid = 1'b0;
      idle(1);
      chk("sat_fffe", 32'(err_count), 32'h0000FFFE);
      s_valid = 1'b1;
      idle(3);
      s_valid = 1'b0;
      idle(1);
      chk("sat_ffff", 32'(err_count), 32'h0000FFFF);

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
